// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock time-keeping slice.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } mode_state_e;

  localparam int unsigned DIGITS = 6;

  // DIGIT_BLANK bit positions for the fields that can be set
  localparam int unsigned BLK_HR_T  = 5;
  localparam int unsigned BLK_HR_U  = 4;
  localparam int unsigned BLK_MIN_T = 3;
  localparam int unsigned BLK_MIN_U = 2;

  // Two-digit BCD limits
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } bcd_time_t;

  // Increment a two-digit BCD field; bit 8 flags the wrap from vmax to 00.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    logic [8:0] r;
    if (v == vmax)              r = 9'h100;
    else if (v[3:0] == 4'd9)    r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                        r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-N counter with a registered pulse during count N-1.
module tick_prescaler #(
  parameter int unsigned N = 2
) (
  input  logic CLK,
  input  logic CLEAR,
  input  logic HOLD,
  output logic TICK,
  output logic ZERO
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q, count_d;

  // HOLD parks the counter at zero so the next period starts fresh
  always_comb begin
    count_d = count_q + W'(1);
    if (HOLD || (count_q == LAST)) count_d = '0;
  end

  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      count_q <= '0;
      TICK    <= 1'b0;
    end else begin
      count_q <= count_d;
      TICK    <= !HOLD && (count_d == LAST);
    end
  end

  assign ZERO = (count_q == '0);

endmodule

// File: rtl/clock_time_ctrl.sv
// BCD hh:mm:ss time keeping with RUN/SET_HR/SET_MIN set-mode and field blinking.
// Define CLOCK_12H_EN for 12-hour display with PM flag (counting stays 24-hour).
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned BLINK_HALF    = TICKS_PER_SEC / 2
) (
  input  logic              CLK,
  input  logic              CLEAR,
  input  logic              MODE_BTN,
  input  logic              INC_BTN,
  output logic [3:0]        HR_T,
  output logic [3:0]        HR_U,
  output logic [3:0]        MIN_T,
  output logic [3:0]        MIN_U,
  output logic [3:0]        SEC_T,
  output logic [3:0]        SEC_U,
  output logic [DIGITS-1:0] DIGIT_BLANK,
  output logic [1:0]        MODE_STATE,
  output logic              TICK_1HZ,
  output logic              PM
);

  mode_state_e       state_q, state_d;
  bcd_time_t         time_q, time_d;
  logic              phase_q, phase_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              sec_tick, sec_zero, sec_hold;
  logic              blink_tick, blink_zero, blink_hold;
  logic [8:0]        sec_inc, min_inc, hr_inc;
  logic              unused_zero;

  // Seconds prescaler runs only in RUN; a MODE press restarts it from zero
  assign sec_hold   = (state_q != ST_RUN) || MODE_BTN;
  assign blink_hold = (state_q == ST_RUN) || MODE_BTN;

  tick_prescaler #(.N(TICKS_PER_SEC)) u_sec_prescaler (
    .CLK   (CLK),
    .CLEAR (CLEAR),
    .HOLD  (sec_hold),
    .TICK  (sec_tick),
    .ZERO  (sec_zero)
  );

  tick_prescaler #(.N(BLINK_HALF)) u_blink_prescaler (
    .CLK   (CLK),
    .CLEAR (CLEAR),
    .HOLD  (blink_hold),
    .TICK  (blink_tick),
    .ZERO  (blink_zero)
  );

  assign unused_zero = sec_zero ^ blink_zero;

  assign sec_inc = bcd_inc({time_q.sec_t, time_q.sec_u}, SEC_MAX);
  assign min_inc = bcd_inc({time_q.min_t, time_q.min_u}, MIN_MAX);
  assign hr_inc  = bcd_inc({time_q.hr_t,  time_q.hr_u},  HR_MAX);

  // Next state, next time and blink phase; MODE always beats INC
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    phase_d = blink_hold ? 1'b0 : (phase_q ^ blink_tick);
    blank_d = '0;
    case (state_q)
      ST_RUN: begin
        if (sec_tick) begin
          {time_d.sec_t, time_d.sec_u} = sec_inc[7:0];
          if (sec_inc[8]) begin
            {time_d.min_t, time_d.min_u} = min_inc[7:0];
            if (min_inc[8]) {time_d.hr_t, time_d.hr_u} = hr_inc[7:0];
          end
        end
        if (MODE_BTN) begin
          state_d      = ST_SET_HR;
          time_d.sec_t = 4'd0;
          time_d.sec_u = 4'd0;
        end
      end
      ST_SET_HR: begin
        if (MODE_BTN)     state_d = ST_SET_MIN;
        else if (INC_BTN) {time_d.hr_t, time_d.hr_u} = hr_inc[7:0];
      end
      ST_SET_MIN: begin
        if (MODE_BTN)     state_d = ST_RUN;
        else if (INC_BTN) {time_d.min_t, time_d.min_u} = min_inc[7:0];
      end
      default: state_d = ST_RUN;
    endcase
    case (state_d)
      ST_SET_HR: begin
        blank_d[BLK_HR_T] = phase_d;
        blank_d[BLK_HR_U] = phase_d;
      end
      ST_SET_MIN: begin
        blank_d[BLK_MIN_T] = phase_d;
        blank_d[BLK_MIN_U] = phase_d;
      end
      default: blank_d = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q <= ST_RUN;
      time_q  <= '0;
      phase_q <= 1'b0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      phase_q <= phase_d;
      blank_q <= blank_d;
    end
  end

  assign MODE_STATE  = state_q;
  assign TICK_1HZ    = sec_tick;
  assign DIGIT_BLANK = blank_q;
  assign MIN_T       = time_q.min_t;
  assign MIN_U       = time_q.min_u;
  assign SEC_T       = time_q.sec_t;
  assign SEC_U       = time_q.sec_u;

`ifdef CLOCK_12H_EN
  logic [4:0] hr_bin, hr12;

  // 0 shows as 12, 13..23 show as 1..11
  assign hr_bin = 5'(time_q.hr_t) * 5'd10 + 5'(time_q.hr_u);

  always_comb begin
    hr12 = hr_bin;
    if (hr_bin == 5'd0)       hr12 = 5'd12;
    else if (hr_bin > 5'd12)  hr12 = hr_bin - 5'd12;
  end

  assign HR_T = (hr12 >= 5'd10) ? 4'd1 : 4'd0;
  assign HR_U = (hr12 >= 5'd10) ? 4'(hr12 - 5'd10) : 4'(hr12);
  assign PM   = (hr_bin >= 5'd12);
`else
  assign HR_T = time_q.hr_t;
  assign HR_U = time_q.hr_u;
  assign PM   = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl with TICKS_PER_SEC=4, BLINK_HALF=2.
module tb_clock_time_ctrl;

  localparam int T = 4;
  localparam int B = 2;

  logic       CLK = 1'b0;
  logic       CLEAR, MODE_BTN, INC_BTN;
  logic [3:0] HR_T, HR_U, MIN_T, MIN_U, SEC_T, SEC_U;
  logic [5:0] DIGIT_BLANK;
  logic [1:0] MODE_STATE;
  logic       TICK_1HZ, PM;

  always #5 CLK = ~CLK;

  clock_time_ctrl #(.TICKS_PER_SEC(T), .BLINK_HALF(B)) dut (
    .CLK(CLK), .CLEAR(CLEAR), .MODE_BTN(MODE_BTN), .INC_BTN(INC_BTN),
    .HR_T(HR_T), .HR_U(HR_U), .MIN_T(MIN_T), .MIN_U(MIN_U), .SEC_T(SEC_T), .SEC_U(SEC_U),
    .DIGIT_BLANK(DIGIT_BLANK), .MODE_STATE(MODE_STATE), .TICK_1HZ(TICK_1HZ), .PM(PM)
  );

  typedef struct packed {
    logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
    logic [5:0] blank;
    logic [1:0] st;
    logic       tick;
    logic       pm;
  } obs_t;

  typedef struct {
    logic mode; logic inc; int reps; int idle;
    int hh; int mm; int ss; int st;
  } row_t;

  row_t rows[$];
  obs_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: plain integer h/m/s, prescaler count, blink count/phase
  int m_h, m_m, m_s, m_cnt, m_bcnt, m_phase, m_st;

  int         k_tick, k_sec;
  logic [7:0] s0;
  logic [5:0] blink_pat [6];
  logic [8:0] exp13, exp00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] disp_hr(input int h);
    int d;
    d = h;
`ifdef CLOCK_12H_EN
    if (h == 0) d = 12;
    else if (h > 12) d = h - 12;
`endif
    return bcd(d);
  endfunction

  function automatic logic pm_of(input int h);
    logic p;
    p = 1'b0;
`ifdef CLOCK_12H_EN
    p = (h >= 12);
`endif
    return p;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    {o.hr_t, o.hr_u}   = disp_hr(m_h);
    {o.min_t, o.min_u} = bcd(m_m);
    {o.sec_t, o.sec_u} = bcd(m_s);
    o.blank = 6'h00;
    if (m_phase != 0 && m_st == 1) o.blank = 6'h30;
    if (m_phase != 0 && m_st == 2) o.blank = 6'h0C;
    o.st   = 2'(m_st);
    o.tick = (m_st == 0 && m_cnt == T - 1);
    o.pm   = pm_of(m_h);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return {HR_T, HR_U, MIN_T, MIN_U, SEC_T, SEC_U, DIGIT_BLANK, MODE_STATE, TICK_1HZ, PM};
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_cnt = 0; m_bcnt = 0; m_phase = 0; m_st = 0;
  endtask

  task automatic model_edge(input logic mode, input logic inc);
    logic tick;
    int   old_st;
    tick   = (m_st == 0 && m_cnt == T - 1);
    old_st = m_st;
    case (m_st)
      0: begin
        if (tick) begin
          m_s++;
          if (m_s == 60) begin
            m_s = 0; m_m++;
            if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
          end
        end
        if (mode) begin m_st = 1; m_s = 0; m_cnt = 0; end
        else m_cnt = (m_cnt + 1) % T;
      end
      1: begin
        m_cnt = 0;
        if (mode) m_st = 2;
        else if (inc) m_h = (m_h + 1) % 24;
      end
      default: begin
        m_cnt = 0;
        if (mode) m_st = 0;
        else if (inc) m_m = (m_m + 1) % 60;
      end
    endcase
    if (old_st == 0 || mode) begin m_bcnt = 0; m_phase = 0; end
    else if (m_bcnt == B - 1) begin m_bcnt = 0; m_phase = 1 - m_phase; end
    else m_bcnt++;
  endtask

  task automatic pop_check(input string name);
    obs_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: got no scoreboard entry expected one", name);
    end else begin
      e = sb.pop_front();
      check(name, 64'(dut_obs()), 64'(e));
    end
  endtask

  // One clock: drive pulses, predict, then compare just after the edge
  task automatic step(input logic mode, input logic inc, input string name = "cycle");
    MODE_BTN = mode;
    INC_BTN  = inc;
    model_edge(mode, inc);
    sb.push_back(model_obs());
    @(posedge CLK);
    #1;
    MODE_BTN = 1'b0;
    INC_BTN  = 1'b0;
    pop_check(name);
  endtask

  task automatic add(input logic mode, input logic inc, input int reps, input int idle,
                     input int hh, input int mm, input int ss, input int st);
    row_t r;
    r.mode = mode; r.inc = inc; r.reps = reps; r.idle = idle;
    r.hh = hh; r.mm = mm; r.ss = ss; r.st = st;
    rows.push_back(r);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add(0, 0,  0,  12,  0,  0,  3, 0);
    add(1, 0,  1,   0,  0,  0,  0, 1);
    add(0, 1, 23,   0, 23,  0,  0, 1);
    add(1, 0,  1,   0, 23,  0,  0, 2);
    add(0, 1, 59,   0, 23, 59,  0, 2);
    add(1, 0,  1,   0, 23, 59,  0, 0);
    add(0, 0,  0, 232, 23, 59, 58, 0);
    add(0, 0,  0,   4, 23, 59, 59, 0);
    add(0, 0,  0,   4,  0,  0,  0, 0);
    add(1, 0,  1,   0,  0,  0,  0, 1);
    add(0, 1, 10,   0, 10,  0,  0, 1);
    add(1, 0,  1,   0, 10,  0,  0, 2);
    add(0, 1, 20,   0, 10, 20,  0, 2);
    add(1, 0,  1,   0, 10, 20,  0, 0);
    add(0, 0,  0, 148, 10, 20, 37, 0);
    add(1, 0,  1,   0, 10, 20,  0, 1);
    add(0, 1, 15,   0,  1, 20,  0, 1);
    add(0, 0,  0,   5,  1, 20,  0, 1);
    add(1, 0,  1,   0,  1, 20,  0, 2);
    add(0, 1, 39,   0,  1, 59,  0, 2);
    add(0, 1,  1,   0,  1,  0,  0, 2);
    add(1, 0,  1,   0,  1,  0,  0, 0);
    add(0, 0,  0,   4,  1,  0,  1, 0);
    add(1, 0,  1,   0,  1,  0,  0, 1);
    add(1, 1,  1,   0,  1,  0,  0, 2);
    add(1, 0,  1,   0,  1,  0,  0, 0);
    add(0, 1,  6,   0,  1,  0,  1, 0);
    add(0, 0,  0, 233,  1,  0, 59, 0);
    add(1, 0,  1,   0,  1,  1,  0, 1);
    add(1, 0,  1,   0,  1,  1,  0, 2);
    add(1, 0,  1,   0,  1,  1,  0, 0);

    blink_pat = '{6'h00, 6'h0C, 6'h0C, 6'h00, 6'h00, 6'h0C};
`ifdef CLOCK_12H_EN
    exp13 = {8'h01, 1'b1};
    exp00 = {8'h12, 1'b0};
`else
    exp13 = {8'h13, 1'b0};
    exp00 = {8'h00, 1'b0};
`endif

    CLEAR = 1'b0; MODE_BTN = 1'b0; INC_BTN = 1'b0;
    #1 CLEAR = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    sb.push_back(model_obs());
    pop_check("reset");
    check("reset_time", 64'({HR_T, HR_U, MIN_T, MIN_U, SEC_T, SEC_U, MODE_STATE}),
          64'({disp_hr(0), 16'h0000, 2'd0}));
    CLEAR = 1'b0;

    for (int i = 0; i < rows.size(); i++) begin
      for (int r = 0; r < rows[i].reps; r++) step(rows[i].mode, rows[i].inc);
      for (int k = 0; k < rows[i].idle; k++) step(1'b0, 1'b0);
      check($sformatf("row%0d", i),
            64'({HR_T, HR_U, MIN_T, MIN_U, SEC_T, SEC_U, MODE_STATE}),
            64'({disp_hr(rows[i].hh), bcd(rows[i].mm), bcd(rows[i].ss), 2'(rows[i].st)}));
    end

    // Tick latency after SET_MIN -> RUN
    k_tick = 0; k_sec = 0;
    s0 = {SEC_T, SEC_U};
    for (int k = 1; k <= 4 * T && k_sec == 0; k++) begin
      step(1'b0, 1'b0, "latency");
      if (TICK_1HZ && k_tick == 0) k_tick = k;
      if ({SEC_T, SEC_U} != s0) k_sec = k;
    end
    check("first_tick_cycle", 64'(k_tick), 64'(T - 1));
    check("first_sec_edge",   64'(k_sec),  64'(T));

    // Blink phase in SET_MIN starts visible and toggles every BLINK_HALF
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, "blink_cycle");
      check($sformatf("blink%0d", i), 64'(DIGIT_BLANK), 64'(blink_pat[i]));
    end

    // Asynchronous clear mid-cycle while blanking is active
    #2 CLEAR = 1'b1;
    #1;
    model_reset();
    sb.push_back(model_obs());
    pop_check("clear_async");
    check("clear_blank", 64'({DIGIT_BLANK, MODE_STATE}), 64'(0));
    @(posedge CLK);
    #1;
    sb.push_back(model_obs());
    pop_check("clear_hold");
    CLEAR = 1'b0;

    // Hour display at 13 and 00
    step(1'b1, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1);
    check("hr13", 64'({HR_T, HR_U, PM}), 64'(exp13));
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1);
    check("hr00", 64'({HR_T, HR_U, PM}), 64'(exp00));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 2 * T; i++) step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
